// File: rtl/dom_pkg.sv
// Shared constants, state codes and a GF(4) reference multiply for the
// masked GF(4) multiplier driver.
package dom_pkg;

  // LFSR geometry: Galois right-shift form of x^16+x^14+x^13+x^11+1.
  localparam int                DOM_LFSR_W    = 16;
  localparam logic [15:0]       DOM_SEED      = 16'hACE1;
  localparam logic [15:0]       DOM_LFSR_POLY = 16'hB400;

  // Two-bit random fields drawn from the LFSR state.
  localparam int TAP_W  = 2;
  localparam int M0_LSB = 0;
  localparam int M1_LSB = 2;
  localparam int R0_LSB = 4;
  localparam int R1_LSB = 6;

  // Driver FSM state codes.
  typedef logic [2:0] dom_state_t;
  localparam dom_state_t ST_IDLE    = 3'd0;
  localparam dom_state_t ST_ARM     = 3'd1;
  localparam dom_state_t ST_EVAL    = 3'd2;
  localparam dom_state_t ST_CAPTURE = 3'd3;
  localparam dom_state_t ST_HOLD    = 3'd4;

  // GF(4) multiply in normal basis {w, w^2}; 2'b11 is the unit element.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

endpackage

// File: rtl/dom_share_driver_lfsr.sv
// Free-running Galois LFSR with synchronous reseed; the all-zero lock-up
// state is never entered, neither from the reset seed nor from a reload.
module dom_lfsr
  import dom_pkg::*;
#(
  parameter int                LFSR_W = DOM_LFSR_W,
  parameter logic [LFSR_W-1:0] SEED   = DOM_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] POLY      = LFSR_W'(DOM_LFSR_POLY);
  localparam logic [LFSR_W-1:0] ONE       = LFSR_W'(1);
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? ONE : SEED;

  // Substitute a nonzero value for an all-zero seed.
  function automatic logic [LFSR_W-1:0] nonzero_seed(input logic [LFSR_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Reload has priority over the per-cycle step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED_SAFE;
    end else if (seed_load) begin
      state <= nonzero_seed(seed_in);
    end else begin
      state <= (state >> 1) ^ (state[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/dom_share_driver.sv
// Masking front-end / unmasking back-end around the two-phase DOM GF(4)
// multiplier: splits one operand pair into Boolean shares, presents them
// with fresh randomness in phase with the multiplier, and recombines only
// the multiplier's output shares.
module dom_share_driver
  import dom_pkg::*;
#(
  parameter int                LFSR_W = DOM_LFSR_W,
  parameter logic [LFSR_W-1:0] SEED   = DOM_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_x,
  input  logic [1:0]        in_y,
  output logic [1:0]        Ax,
  output logic [1:0]        Bx,
  output logic [1:0]        Ay,
  output logic [1:0]        By,
  output logic [1:0]        Z0,
  output logic [1:0]        Z1,
  input  logic [1:0]        Aq,
  input  logic [1:0]        Bq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_q,
  output logic              phase
);

  logic [LFSR_W-1:0] lfsr;
  logic [TAP_W-1:0]  m0, m1, r0, r1;
  logic              lfsr_unused;
  dom_state_t        state, state_nxt;

  dom_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state     (lfsr)
  );

  assign m0 = lfsr[M0_LSB +: TAP_W];
  assign m1 = lfsr[M1_LSB +: TAP_W];
  assign r0 = lfsr[R0_LSB +: TAP_W];
  assign r1 = lfsr[R1_LSB +: TAP_W];

  // Upper LFSR bits only lengthen the period; they are never tapped.
  assign lfsr_unused = ^lfsr[LFSR_W-1:R1_LSB+TAP_W];

  assign in_ready = (state == ST_IDLE);

  // Phase mirror: leaves reset with the multiplier, so 0 marks its PHASE1 edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: ARM waits until the coming edge is the multiplier's PHASE1 edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (in_valid)  state_nxt = ST_ARM;
      ST_ARM:     if (!phase)    state_nxt = ST_EVAL;
      ST_EVAL:                   state_nxt = ST_CAPTURE;
      ST_CAPTURE:                state_nxt = ST_HOLD;
      ST_HOLD:    if (out_ready) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Share/randomness buses and result register. Shares are registered once
  // on accept, so a later reseed cannot alter them; the unmasked operands
  // are never stored and the only recombination is of the output shares.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Ax        <= '0;
      Bx        <= '0;
      Ay        <= '0;
      By        <= '0;
      Z0        <= '0;
      Z1        <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            Ax <= in_x ^ m0;
            Bx <= m0;
            Ay <= in_y ^ m1;
            By <= m1;
            Z0 <= r0;
            Z1 <= r1;
          end
        end
        ST_CAPTURE: begin
          out_q     <= Aq ^ Bq;
          out_valid <= 1'b1;
          Ax        <= '0;
          Bx        <= '0;
          Ay        <= '0;
          By        <= '0;
          Z0        <= '0;
          Z1        <= '0;
        end
        ST_HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
